// File: rtl/ring_pkg.sv
// Shared types and seed values for the ring/Johnson shift-register counter.
package ring_pkg;

    typedef enum logic {
        RING    = 1'b0,
        JOHNSON = 1'b1
    } mode_e;

    // Widest counter whose seed this function can describe.
    localparam int unsigned SEED_W = 64;

    // RING restarts from a single set bit 0; JOHNSON restarts from all zeros.
    function automatic logic [SEED_W-1:0] seed(mode_e m, int unsigned w);
        logic [SEED_W-1:0] s;
        s = '0;
        if (m == RING && w > 0)
            s[0] = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/ring_state_check.sv
// Legality decode: one-hot for RING, at most one adjacent-bit edge for JOHNSON.
module ring_state_check
    import ring_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] state,
    input  mode_e            mode,
    output logic             legal
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] pop;
    logic [CW-1:0] trans;

    always_comb begin
        pop   = '0;
        trans = '0;
        for (int i = 0; i < WIDTH; i++)
            pop = pop + CW'(state[i]);
        for (int i = 0; i < WIDTH - 1; i++)
            trans = trans + CW'(state[i] ^ state[i+1]);
    end

    assign legal = (mode == RING) ? (pop == CW'(1)) : (trans <= CW'(1));

endmodule

// File: rtl/ring_counter_gen.sv
// Ring / Johnson shift counter with load, direction, self-correction and wrap pulse.
module ring_counter_gen
    import ring_pkg::*;
#(
    parameter int WIDTH = 4   // 2 .. SEED_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic             err,
    output logic             legal
);

    mode_e            mode_in;
    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] seed_v, step_v, out_d;
    logic             fb, wrap_d, err_d;

    assign mode_in = mode_e'(mode);
    assign seed_v  = WIDTH'(seed(mode_in, WIDTH));

    ring_state_check #(.WIDTH(WIDTH)) u_chk (
        .state (out),
        .mode  (mode_in),
        .legal (legal)
    );

    // Feedback bit is the end shifted out, inverted in Johnson mode.
    assign fb     = (dir ? out[WIDTH-1] : out[0]) ^ (mode_in == JOHNSON);
    assign step_v = dir ? {out[WIDTH-2:0], fb} : {fb, out[WIDTH-1:1]};

    always_comb begin
        out_d  = out;
        mode_d = mode_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (mode_in != mode_q) begin
            out_d  = seed_v;
            mode_d = mode_in;
        end else if (load) begin
            out_d = load_val;
        end else if (en && !legal) begin
            out_d = seed_v;
            err_d = 1'b1;
        end else if (en) begin
            out_d  = step_v;
            wrap_d = (step_v == seed_v);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out    <= WIDTH'(1);
            mode_q <= RING;
            wrap   <= 1'b0;
            err    <= 1'b0;
        end else begin
            out    <= out_d;
            mode_q <= mode_d;
            wrap   <= wrap_d;
            err    <= err_d;
        end
    end

endmodule

// File: tb/tb_ring_counter_gen.sv
// Directed and randomized check of ring_counter_gen against a behavioural model.
module tb_ring_counter_gen;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset, en, dir, mode, load;
    logic [W-1:0] load_val;
    logic [W-1:0] out;
    logic         wrap, err, legal;

    int n_chk  = 0;
    int n_fail = 0;

    // model state
    logic [W-1:0] m_out;
    logic         m_modeq, m_wrap, m_err;

    always #5 clk = ~clk;

    ring_counter_gen #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .out      (out),
        .wrap     (wrap),
        .err      (err),
        .legal    (legal)
    );

    function automatic logic [W-1:0] m_seed(logic md);
        return md ? '0 : W'(1);
    endfunction

    function automatic bit m_legal(logic [W-1:0] v, logic md);
        int edges;
        if (!md)
            return $countones(v) == 1;
        edges = 0;
        for (int i = 0; i < W - 1; i++)
            if (v[i] != v[i+1]) edges++;
        return edges <= 1;
    endfunction

    function automatic logic [W-1:0] m_step(logic [W-1:0] v, logic md, logic d);
        logic [W-1:0] n;
        if (!d) begin
            for (int i = 0; i < W - 1; i++) n[i] = v[i+1];
            n[W-1] = md ? ~v[0] : v[0];
        end else begin
            for (int i = 1; i < W; i++) n[i] = v[i-1];
            n[0] = md ? ~v[W-1] : v[W-1];
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_model();
        chk("out",   out,      m_out);
        chk("wrap",  W'(wrap),  W'(m_wrap));
        chk("err",   W'(err),   W'(m_err));
        chk("legal", W'(legal), W'(m_legal(m_out, mode)));
    endtask

    task automatic model_reset();
        m_out   = W'(1);
        m_modeq = 1'b0;
        m_wrap  = 1'b0;
        m_err   = 1'b0;
    endtask

    // Advance model with the inputs present before the edge, then compare.
    task automatic tick();
        logic [W-1:0] n_out, nx;
        logic         n_mq, n_w, n_e;
        n_out = m_out; n_mq = m_modeq; n_w = 1'b0; n_e = 1'b0;
        if (mode != m_modeq) begin
            n_out = m_seed(mode); n_mq = mode;
        end else if (load) begin
            n_out = load_val;
        end else if (en && !m_legal(m_out, mode)) begin
            n_out = m_seed(mode); n_e = 1'b1;
        end else if (en) begin
            nx = m_step(m_out, mode, dir);
            n_out = nx; n_w = (nx == m_seed(mode));
        end
        @(posedge clk);
        #1;
        m_out = n_out; m_modeq = n_mq; m_wrap = n_w; m_err = n_e;
        check_model();
    endtask

    logic [W-1:0] ring_seq [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [W-1:0] john_seq [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                   4'b1110, 4'b1100, 4'b1000, 4'b0000};

    initial begin
        reset = 1'b0; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_val = '0;
        model_reset();
        #12;
        chk("rst_out", out, 4'b0001);
        chk("rst_wrap_err", W'({wrap, err}), '0);
        chk("rst_legal", W'(legal), W'(1));
        @(negedge clk); reset = 1'b1;

        // RING, shift down
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ring_seq", out, ring_seq[i]);
            chk("ring_wrap", W'(wrap), W'(i == 3));
        end

        // JOHNSON, shift up: mode change reseeds first
        mode = 1'b1; dir = 1'b1;
        tick();
        chk("j_seed", out, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("john_seq", out, john_seq[i]);
            chk("john_wrap", W'(wrap), W'(i == 7));
        end

        // illegal load then self-correct
        mode = 1'b0; dir = 1'b0; en = 1'b0;
        tick();
        load = 1'b1; load_val = 4'b0110;
        tick();
        chk("ld_out", out, 4'b0110);
        chk("ld_legal", W'(legal), '0);
        load = 1'b0; en = 1'b1;
        tick();
        chk("corr_out", out, 4'b0001);
        chk("corr_err", W'({err, wrap}), W'(2'b10));

        // mode toggle at 0100 while en high
        tick(); tick();
        chk("pre_toggle", out, 4'b0100);
        mode = 1'b1;
        tick();
        chk("toggle_out", out, 4'b0000);
        chk("toggle_flags", W'({wrap, err}), '0);
        tick();
        chk("toggle_step", out, 4'b1000);

        // load beats en, then direction flips
        mode = 1'b0;
        tick();
        load = 1'b1; load_val = 4'b0010;
        tick();
        chk("ld_en", out, 4'b0010);
        load = 1'b0; dir = 1'b1;
        tick();
        chk("dir_up", out, 4'b0100);
        dir = 1'b0;
        tick();
        chk("dir_dn", out, 4'b0010);

        // async reset mid-cycle in JOHNSON at 0100
        mode = 1'b1;
        tick();
        load = 1'b1; load_val = 4'b0100;
        tick();
        chk("j_0100", out, 4'b0100);
        load = 1'b0;
        #3 reset = 1'b0;
        #1;
        model_reset();
        chk("arst_out", out, 4'b0001);
        chk("arst_flags", W'({wrap, err}), '0);
        @(negedge clk); reset = 1'b1;
        tick();
        chk("post_rst", out, 4'b0000);

        // randomized phase
        for (int c = 0; c < 400; c++) begin
            en       = ($urandom_range(0, 3) != 0);
            dir      = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            load     = ($urandom_range(0, 9) == 0);
            load_val = W'($urandom);
            tick();
            if ($urandom_range(0, 49) == 0) begin
                #2 reset = 1'b0;
                #1;
                model_reset();
                check_model();
                #2 reset = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
